// File: rtl/imem_loader_if.sv
// Valid/ready stream that carries instruction words into imem_loader.
// The master drives words; the loader (slave) answers with wr_ready.
interface imem_loader_if;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_last;
    logic        wr_ready;

    modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/imem_loader.sv
// Fills the riscv core's 32 instruction slots from a word stream, then releases core reset.
// Optional LOADER_CHECKSUM_EN adds chk_out/chk_valid: XOR of the words accepted in the last load.
module imem_loader #(
    parameter int          NUM_WORDS  = 32,
    parameter int          RST_CYCLES = 5,
    parameter logic [31:0] FILL_WORD  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    imem_loader_if.slave wr,
    output logic [31:0] idata0,  idata1,  idata2,  idata3,  idata4,  idata5,  idata6,  idata7,
    output logic [31:0] idata8,  idata9,  idata10, idata11, idata12, idata13, idata14, idata15,
    output logic [31:0] idata16, idata17, idata18, idata19, idata20, idata21, idata22, idata23,
    output logic [31:0] idata24, idata25, idata26, idata27, idata28, idata29, idata30, idata31,
    output logic        core_rst,
    output logic        load_done,
    output logic [5:0]  word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0] chk_out,
    output logic        chk_valid
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] slots [32];
    logic [7:0]  hold_cnt;
    logic        accept;
    logic        clear;
    logic        last_word;
    logic        hold_done;

    assign accept    = wr.wr_valid && wr.wr_ready;
    assign clear     = load_start && (state == IDLE || state == RUN);
    assign last_word = wr.wr_last || (word_count == 6'(NUM_WORDS - 1));
    assign hold_done = (hold_cnt == 8'(RST_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load_start)          next_state = LOAD;
            LOAD:    if (accept && last_word) next_state = HOLD;
            HOLD:    if (hold_done)           next_state = RUN;
            RUN:     if (load_start)          next_state = LOAD;
            default:                          next_state = IDLE;
        endcase
    end

    always_comb begin
        wr.wr_ready = (state == LOAD);
    end

    // Core reset and done flag are registered from next_state so they flip on the edge entering RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_rst  <= 1'b1;
            load_done <= 1'b0;
        end else begin
            core_rst  <= (next_state != RUN);
            load_done <= (next_state == RUN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= 8'd0;
        end else if (state == HOLD && !hold_done) begin
            hold_cnt <= hold_cnt + 8'd1;
        end else begin
            hold_cnt <= 8'd0;
        end
    end

    // Only slots below NUM_WORDS are ever written; the rest keep FILL_WORD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) slots[i] <= FILL_WORD;
            word_count <= 6'd0;
        end else if (clear) begin
            for (int i = 0; i < 32; i++) slots[i] <= FILL_WORD;
            word_count <= 6'd0;
        end else if (accept) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (word_count == 6'(i)) slots[i] <= wr.wr_data;
            end
            if (word_count < 6'(NUM_WORDS)) word_count <= word_count + 6'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_out <= 32'd0;
        end else if (clear) begin
            chk_out <= 32'd0;
        end else if (accept) begin
            chk_out <= chk_out ^ wr.wr_data;
        end
    end

    assign chk_valid = (state == HOLD) || (state == RUN);
`endif

    assign idata0  = slots[0];
    assign idata1  = slots[1];
    assign idata2  = slots[2];
    assign idata3  = slots[3];
    assign idata4  = slots[4];
    assign idata5  = slots[5];
    assign idata6  = slots[6];
    assign idata7  = slots[7];
    assign idata8  = slots[8];
    assign idata9  = slots[9];
    assign idata10 = slots[10];
    assign idata11 = slots[11];
    assign idata12 = slots[12];
    assign idata13 = slots[13];
    assign idata14 = slots[14];
    assign idata15 = slots[15];
    assign idata16 = slots[16];
    assign idata17 = slots[17];
    assign idata18 = slots[18];
    assign idata19 = slots[19];
    assign idata20 = slots[20];
    assign idata21 = slots[21];
    assign idata22 = slots[22];
    assign idata23 = slots[23];
    assign idata24 = slots[24];
    assign idata25 = slots[25];
    assign idata26 = slots[26];
    assign idata27 = slots[27];
    assign idata28 = slots[28];
    assign idata29 = slots[29];
    assign idata30 = slots[30];
    assign idata31 = slots[31];

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a cycle table, directed corner sequences, and random loads
// checked against a queue-based model of the words the loader should hold.
module tb_imem_loader;

    localparam logic [31:0] FILL = 32'h00000013;
    localparam int          RSTC = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [31:0] idata [32];
    logic        core_rst;
    logic        load_done;
    logic [5:0]  word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] chk_out;
    logic        chk_valid;
`endif

    int checks = 0;
    int passed = 0;
    logic [31:0] model_q [$];

    imem_loader_if bus ();

    imem_loader dut (
        .clk(clk), .reset(reset), .load_start(load_start), .wr(bus),
        .idata0(idata[0]),   .idata1(idata[1]),   .idata2(idata[2]),   .idata3(idata[3]),
        .idata4(idata[4]),   .idata5(idata[5]),   .idata6(idata[6]),   .idata7(idata[7]),
        .idata8(idata[8]),   .idata9(idata[9]),   .idata10(idata[10]), .idata11(idata[11]),
        .idata12(idata[12]), .idata13(idata[13]), .idata14(idata[14]), .idata15(idata[15]),
        .idata16(idata[16]), .idata17(idata[17]), .idata18(idata[18]), .idata19(idata[19]),
        .idata20(idata[20]), .idata21(idata[21]), .idata22(idata[22]), .idata23(idata[23]),
        .idata24(idata[24]), .idata25(idata[25]), .idata26(idata[26]), .idata27(idata[27]),
        .idata28(idata[28]), .idata29(idata[29]), .idata30(idata[30]), .idata31(idata[31]),
        .core_rst(core_rst), .load_done(load_done), .word_count(word_count)
`ifdef LOADER_CHECKSUM_EN
        , .chk_out(chk_out), .chk_valid(chk_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ls;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        ready;
        logic        crst;
        logic        done;
        logic [5:0]  wc;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    function automatic logic [31:0] model_slot(input int i);
        return (i < model_q.size()) ? model_q[i] : FILL;
    endfunction

    function automatic logic [31:0] model_xor();
        logic [31:0] r = 32'd0;
        foreach (model_q[i]) r ^= model_q[i];
        return r;
    endfunction

    task automatic check_bank(input string tag);
        for (int i = 0; i < 32; i++)
            checkOutput($sformatf("%s slot%0d", tag, i), idata[i], model_slot(i));
    endtask

    task automatic applyStimulus(input vec_t v);
        load_start   = v.ls;
        bus.wr_valid = v.valid;
        bus.wr_data  = v.data;
        bus.wr_last  = v.last;
        tick();
        load_start   = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        model_q.delete();
        checkOutput({tag, " start wr_ready"}, 32'(bus.wr_ready), 32'd1);
        checkOutput({tag, " start core_rst"}, 32'(core_rst), 32'd1);
        checkOutput({tag, " start load_done"}, 32'(load_done), 32'd0);
        checkOutput({tag, " start word_count"}, 32'(word_count), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        checkOutput({tag, " start chk_out"}, chk_out, 32'd0);
        checkOutput({tag, " start chk_valid"}, 32'(chk_valid), 32'd0);
`endif
    endtask

    // Holds a word on the bus until the loader takes it, bounded so a stuck DUT still finishes.
    task automatic send_word(input logic [31:0] data, input logic last);
        int waited = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = data;
        bus.wr_last  = last;
        while (!bus.wr_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.wr_ready) begin
            checks++;
            $display("[TB] FAIL send timeout: wr_ready=0, expected 1");
        end else begin
            tick();
            model_q.push_back(data);
        end
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic hold_phase(input string tag, input bit noise);
        for (int k = 1; k <= RSTC; k++) begin
            if (noise) begin
                load_start   = 1'($urandom % 2);
                bus.wr_valid = 1'($urandom % 2);
                bus.wr_data  = $urandom;
            end
            tick();
            load_start   = 1'b0;
            bus.wr_valid = 1'b0;
            checkOutput($sformatf("%s hold%0d core_rst", tag, k), 32'(core_rst), 32'(k < RSTC));
            checkOutput($sformatf("%s hold%0d load_done", tag, k), 32'(load_done), 32'(k == RSTC));
            checkOutput($sformatf("%s hold%0d wr_ready", tag, k), 32'(bus.wr_ready), 32'd0);
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        bit use_last;

        load_start   = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 32'd0;
        bus.wr_last  = 1'b0;
        model_q.delete();

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        check_bank("reset");
        checkOutput("reset core_rst", 32'(core_rst), 32'd1);
        checkOutput("reset wr_ready", 32'(bus.wr_ready), 32'd0);
        checkOutput("reset load_done", 32'(load_done), 32'd0);
        checkOutput("reset word_count", 32'(word_count), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        checkOutput("reset chk_out", chk_out, 32'd0);
        checkOutput("reset chk_valid", 32'(chk_valid), 32'd0);
`endif
        reset = 1'b1;
        tick();

        // Cycle table: two-word load, ignored starts/words in LOAD/HOLD/RUN, restart from RUN
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 6'd0, FILL,          FILL,          FILL};
        vecs[1]  = '{1'b0, 1'b1, 32'hAAAA0001, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 32'hAAAA0001, FILL,          FILL};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 32'hAAAA0001, FILL,          FILL};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 32'hAAAA0001, FILL,          FILL};
        vecs[4]  = '{1'b0, 1'b1, 32'hBBBB0002, 1'b1, 1'b0, 1'b1, 1'b0, 6'd2, 32'hAAAA0001, 32'hBBBB0002, FILL};
        vecs[5]  = '{1'b1, 1'b1, 32'hCCCC0003, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2, 32'hAAAA0001, 32'hBBBB0002, FILL};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 6'd2, 32'hAAAA0001, 32'hBBBB0002, FILL};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 6'd2, 32'hAAAA0001, 32'hBBBB0002, FILL};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 6'd2, 32'hAAAA0001, 32'hBBBB0002, FILL};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 32'hAAAA0001, 32'hBBBB0002, FILL};
        vecs[10] = '{1'b0, 1'b1, 32'hDDDD0004, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 32'hAAAA0001, 32'hBBBB0002, FILL};
        vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 6'd0, FILL,          FILL,          FILL};
        for (int r = 0; r < 12; r++) begin
            applyStimulus(vecs[r]);
            checkOutput($sformatf("vec%0d wr_ready", r), 32'(bus.wr_ready), 32'(vecs[r].ready));
            checkOutput($sformatf("vec%0d core_rst", r), 32'(core_rst), 32'(vecs[r].crst));
            checkOutput($sformatf("vec%0d load_done", r), 32'(load_done), 32'(vecs[r].done));
            checkOutput($sformatf("vec%0d word_count", r), 32'(word_count), 32'(vecs[r].wc));
            checkOutput($sformatf("vec%0d slot0", r), idata[0], vecs[r].s0);
            checkOutput($sformatf("vec%0d slot1", r), idata[1], vecs[r].s1);
            checkOutput($sformatf("vec%0d slot2", r), idata[2], vecs[r].s2);
        end

        // 19-word load terminated by wr_last
        reset = 1'b0;
        tick();
        reset = 1'b1;
        pulse_start("t2");
        send_word(32'h12345337, 1'b0);
        send_word(32'h67830313, 1'b0);
        for (int i = 2; i < 19; i++) send_word($urandom, 1'(i == 18));
        checkOutput("t2 hold word_count", 32'(word_count), 32'd19);
        checkOutput("t2 hold core_rst", 32'(core_rst), 32'd1);
        hold_phase("t2", 1'b0);
        check_bank("t2 run");
        checkOutput("t2 run word_count", 32'(word_count), 32'(model_q.size()));

        // 32 words, valid toggled every other cycle, no wr_last: fills and saturates
        pulse_start("t3");
        for (int i = 0; i < 32; i++) begin
            send_word($urandom, 1'b0);
            if (i < 31) tick();
        end
        checkOutput("t3 word_count", 32'(word_count), 32'd32);
        checkOutput("t3 wr_ready", 32'(bus.wr_ready), 32'd0);
        checkOutput("t3 core_rst", 32'(core_rst), 32'd1);
        hold_phase("t3", 1'b1);
        check_bank("t3 run");
        checkOutput("t3 run word_count", 32'(word_count), 32'd32);

        // Reset in the middle of a load discards the partial bank; later words are dropped
        pulse_start("t4");
        for (int i = 0; i < 7; i++) send_word($urandom, 1'b0);
        reset = 1'b0;
        #1;
        model_q.delete();
        check_bank("t4 reset");
        checkOutput("t4 reset core_rst", 32'(core_rst), 32'd1);
        checkOutput("t4 reset wr_ready", 32'(bus.wr_ready), 32'd0);
        checkOutput("t4 reset word_count", 32'(word_count), 32'd0);
        checkOutput("t4 reset load_done", 32'(load_done), 32'd0);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = $urandom;
            checkOutput($sformatf("t4 drop%0d wr_ready", i), 32'(bus.wr_ready), 32'd0);
            tick();
        end
        bus.wr_valid = 1'b0;
        check_bank("t4 dropped");
        checkOutput("t4 dropped word_count", 32'(word_count), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum of a two-word load
        pulse_start("t6");
        send_word(32'h0000000F, 1'b0);
        send_word(32'h000000F0, 1'b1);
        checkOutput("t6 chk_out", chk_out, 32'h000000FF);
        checkOutput("t6 chk_valid", 32'(chk_valid), 32'd1);
        hold_phase("t6", 1'b0);
        checkOutput("t6 run chk_valid", 32'(chk_valid), 32'd1);
`endif

        // Random loads with idle gaps and ignored starts/words
        for (int n = 0; n < 15; n++) begin
            pulse_start($sformatf("rnd%0d", n));
            check_bank($sformatf("rnd%0d cleared", n));
            len      = int'($urandom_range(32, 1));
            use_last = (len < 32) ? 1'b1 : 1'($urandom % 2);
            for (int w = 0; w < len; w++) begin
                for (int g = int'($urandom_range(2, 0)); g > 0; g--) begin
                    load_start = 1'($urandom % 2);
                    tick();
                    load_start = 1'b0;
                end
                send_word($urandom, 1'(use_last && (w == len - 1)));
            end
            checkOutput($sformatf("rnd%0d word_count", n), 32'(word_count), 32'(model_q.size()));
            checkOutput($sformatf("rnd%0d wr_ready", n), 32'(bus.wr_ready), 32'd0);
`ifdef LOADER_CHECKSUM_EN
            checkOutput($sformatf("rnd%0d chk_out", n), chk_out, model_xor());
            checkOutput($sformatf("rnd%0d chk_valid", n), 32'(chk_valid), 32'd1);
`endif
            hold_phase($sformatf("rnd%0d", n), 1'b1);
            for (int i = 0; i < 2; i++) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = $urandom;
                tick();
            end
            bus.wr_valid = 1'b0;
            check_bank($sformatf("rnd%0d run", n));
            checkOutput($sformatf("rnd%0d run load_done", n), 32'(load_done), 32'd1);
        end

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
